// File: rtl/rom_arb_pkg.sv
// Shared constants and types for the two-requester ROM read arbiter.
package rom_arb_pkg;

  localparam int unsigned ADDR_W_DEF  = 5;
  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned RSP_LATENCY = 2;

  // Requester identifier: 0 or 1.
  typedef logic req_id_t;

  // One in-flight slot of the response-tracking pipeline.
  typedef struct packed {
    logic    valid;
    req_id_t id;
  } inflight_t;

endpackage

// File: rtl/rom_arb_rr.sv
// Two-way round-robin selector: when both requesters are valid, the one
// named by the priority pointer wins; otherwise the single valid one wins.
module rom_arb_rr
  import rom_arb_pkg::*;
(
  input  logic       valid0,
  input  logic       valid1,
  input  req_id_t    ptr,
  output logic [1:0] grant
);

  // One-hot grant from the valids and the priority holder.
  always_comb begin
    grant = '0;
    if (valid0 && valid1) begin
      grant[ptr] = 1'b1;
    end else if (valid0) begin
      grant[0] = 1'b1;
    end else if (valid1) begin
      grant[1] = 1'b1;
    end
  end

endmodule

// File: rtl/rom_read_arbiter.sv
// Arbitrates two read requesters onto one single-port ROM with a fixed
// two-cycle response latency and one acceptance per cycle.
// Optional build macro ROM_ARB_STATS_EN adds per-requester saturating
// acceptance counters (grant_cnt0 / grant_cnt1).
module rom_read_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req0_ready,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
`ifdef ROM_ARB_STATS_EN
  ,
  output logic [15:0]       grant_cnt0,
  output logic [15:0]       grant_cnt1
`endif
);

  logic        [1:0]  grant;
  req_id_t            ptr;
  logic               accept;
  req_id_t            acc_id;
  logic [ADDR_W-1:0]  acc_addr;
  inflight_t          pipe [RSP_LATENCY];
  inflight_t          pipe_out;

  rom_arb_rr u_rr (
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .ptr    (ptr),
    .grant  (grant)
  );

  // Readiness is held low during reset so nothing is accepted while the
  // pipeline is being cleared.
  always_comb begin
    req0_ready = grant[0] & ~rst;
    req1_ready = grant[1] & ~rst;
    accept     = req0_ready | req1_ready;
    acc_id     = req_id_t'(req1_ready);
    acc_addr   = req1_ready ? req1_addr : req0_addr;
  end

  // Pointer, ROM address register and in-flight {valid, id} shift pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= 1'b0;
      rom_addr <= '0;
      for (int unsigned i = 0; i < RSP_LATENCY; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      if (accept) begin
        ptr      <= ~acc_id;
        rom_addr <= acc_addr;
      end
      pipe[0] <= '{valid: accept, id: acc_id};
      for (int unsigned i = 1; i < RSP_LATENCY; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  // Response steering from the last pipeline stage; ROM data passes straight
  // through since it lines up with that stage.
  always_comb begin
    pipe_out   = pipe[RSP_LATENCY-1];
    rsp0_valid = pipe_out.valid & (pipe_out.id == 1'b0) & ~rst;
    rsp1_valid = pipe_out.valid & (pipe_out.id == 1'b1) & ~rst;
    rsp_data   = rom_data;
  end

`ifdef ROM_ARB_STATS_EN
  // Saturating per-requester acceptance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (req0_ready && grant_cnt0 != '1) grant_cnt0 <= grant_cnt0 + 16'd1;
      if (req1_ready && grant_cnt1 != '1) grant_cnt1 <= grant_cnt1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Self-checking bench for rom_read_arbiter: directed scenarios plus random
// traffic checked against a transaction-level reference model.
// Define ROM_ARB_STATS_EN to also exercise the acceptance counters.
module tb_rom_read_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [4:0] req0_addr, req1_addr;
  logic       req0_ready, req1_ready;
  logic       rsp0_valid, rsp1_valid;
  logic [7:0] rsp_data;
  logic [4:0] rom_addr;
  logic [7:0] rom_q;
`ifdef ROM_ARB_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  rom_read_arbiter #(.ADDR_W(5), .DATA_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .req0_addr  (req0_addr),
    .req1_addr  (req1_addr),
    .req0_ready (req0_ready),
    .req1_ready (req1_ready),
    .rsp0_valid (rsp0_valid),
    .rsp1_valid (rsp1_valid),
    .rsp_data   (rsp_data),
    .rom_addr   (rom_addr),
    .rom_data   (rom_q)
`ifdef ROM_ARB_STATS_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  // ROM: one-cycle registered read, contents = addr + 0x10.
  always @(posedge clk) rom_q <= {3'b000, rom_addr} + 8'h10;

  // ---------------- reference model ----------------
  typedef struct {
    int       due;
    bit       id;
    bit [7:0] data;
  } exp_t;

  exp_t sb[$];
  bit   m_ptr = 1'b0;
  int   m_cnt0 = 0, m_cnt1 = 0;

  function automatic logic [1:0] model_grant(input logic v0, input logic v1, input bit p);
    if (v0 && v1) return p ? 2'b10 : 2'b01;
    return {v1, v0};
  endfunction

  // Acceptances become expected responses two cycles later.
  always @(posedge clk) begin
    logic [1:0] g;
    bit         id;
    if (rst) begin
      m_ptr  = 1'b0;
      sb.delete();
      m_cnt0 = 0;
      m_cnt1 = 0;
    end else begin
      g = model_grant(req0_valid, req1_valid, m_ptr);
      if (g != 2'b00) begin
        id = g[1];
        sb.push_back('{due: cyc + 2, id: id,
                       data: {3'b000, (id ? req1_addr : req0_addr)} + 8'h10});
        m_ptr = ~id;
        if (id) begin if (m_cnt1 < 65535) m_cnt1++; end
        else    begin if (m_cnt0 < 65535) m_cnt0++; end
      end
    end
    cyc++;
  end

  // Every cycle: readies and responses against the model.
  always @(negedge clk) begin
    logic [1:0] g;
    bit e0, e1;
    bit [7:0] ed;
    g  = rst ? 2'b00 : model_grant(req0_valid, req1_valid, m_ptr);
    e0 = 1'b0; e1 = 1'b0; ed = 8'h00;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e0 = !rst && !sb[0].id;
      e1 = !rst &&  sb[0].id;
      ed = sb[0].data;
      void'(sb.pop_front());
    end
    checks++;
    if (req0_ready !== g[0]) begin
      errors++; $display("FAIL mon_ready0 cyc=%0d got=%b exp=%b", cyc, req0_ready, g[0]);
    end
    checks++;
    if (req1_ready !== g[1]) begin
      errors++; $display("FAIL mon_ready1 cyc=%0d got=%b exp=%b", cyc, req1_ready, g[1]);
    end
    checks++;
    if (rsp0_valid !== e0) begin
      errors++; $display("FAIL mon_rsp0 cyc=%0d got=%b exp=%b", cyc, rsp0_valid, e0);
    end
    checks++;
    if (rsp1_valid !== e1) begin
      errors++; $display("FAIL mon_rsp1 cyc=%0d got=%b exp=%b", cyc, rsp1_valid, e1);
    end
    if (e0 || e1) begin
      checks++;
      if (rsp_data !== ed) begin
        errors++; $display("FAIL mon_data cyc=%0d got=%h exp=%h", cyc, rsp_data, ed);
      end
    end
    checks++;
    if (rsp0_valid === 1'b1 && rsp1_valid === 1'b1) begin
      errors++; $display("FAIL mon_both_rsp cyc=%0d got=11 exp=not both", cyc);
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; req0_addr = 5'd7; req1_addr = 5'd9;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++; $display("FAIL reset_ready got=%b%b exp=00", req1_ready, req0_ready);
      end
      checks++;
      if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
        errors++; $display("FAIL reset_rsp got=%b%b exp=00", rsp1_valid, rsp0_valid);
      end
      checks++;
      if (rom_addr !== 5'd0) begin
        errors++; $display("FAIL reset_rom_addr got=%0d exp=0", rom_addr);
      end
    end
  endtask

  task automatic test_single();
    @(posedge clk); #1;
    rst = 1'b0; req0_valid = 1'b1; req0_addr = 5'd3; req1_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL single_ready got=%b%b exp=01", req1_ready, req0_ready);
    end
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      req0_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (rsp0_valid !== (i == 2)) begin
        errors++; $display("FAIL single_rsp0 offset=%0d got=%b exp=%b", i, rsp0_valid, (i == 2));
      end
      if (i == 2) begin
        checks++;
        if (rsp_data !== 8'h13) begin
          errors++; $display("FAIL single_data got=%h exp=13", rsp_data);
        end
      end
    end
  endtask

  task automatic test_contention();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1; rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    end
    @(posedge clk); #1;
    rst = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1; req0_addr = 5'd0; req1_addr = 5'd31;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
        if (i == 8) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      end
      @(negedge clk);
      if (i < 8) begin
        checks++;
        if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin
          errors++; $display("FAIL contention_grant i=%0d got=%b%b exp=%b%b",
                             i, req1_ready, req0_ready, (i % 2 == 1), (i % 2 == 0));
        end
      end
      if (i >= 2) begin
        checks++;
        if (rsp0_valid !== (i % 2 == 0) || rsp1_valid !== (i % 2 == 1)) begin
          errors++; $display("FAIL contention_rsp i=%0d got=%b%b exp=%b%b",
                             i, rsp1_valid, rsp0_valid, (i % 2 == 1), (i % 2 == 0));
        end
        checks++;
        if (rsp_data !== ((i % 2 == 0) ? 8'h10 : 8'h2F)) begin
          errors++; $display("FAIL contention_data i=%0d got=%h exp=%h",
                             i, rsp_data, ((i % 2 == 0) ? 8'h10 : 8'h2F));
        end
      end
    end
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      req0_valid = 1'b0;
      req1_valid = (i < 8);
      req1_addr  = 5'(i);
      @(negedge clk);
      if (i < 8) begin
        checks++;
        if (req1_ready !== 1'b1) begin
          errors++; $display("FAIL stream_ready i=%0d got=%b exp=1", i, req1_ready);
        end
      end
      if (i >= 2) begin
        checks++;
        if (rsp1_valid !== 1'b1 || rsp_data !== 8'(8'h10 + i - 2)) begin
          errors++; $display("FAIL stream_rsp i=%0d got=%b/%h exp=1/%h",
                             i, rsp1_valid, rsp_data, 8'(8'h10 + i - 2));
        end
      end
    end
    @(posedge clk); #1; req1_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp1_valid !== 1'b0) begin
      errors++; $display("FAIL stream_end got=%b exp=0", rsp1_valid);
    end
  endtask

  task automatic test_reset_midflight();
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_addr = 5'd9; req1_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_accept got=%b exp=1", req0_ready);
    end
    @(posedge clk); #1;
    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      @(negedge clk);
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++; $display("FAIL midrst_ready N+%0d got=%b%b exp=00", k, req1_ready, req0_ready);
      end
      checks++;
      if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
        errors++; $display("FAIL midrst_rsp N+%0d got=%b%b exp=00", k, rsp1_valid, rsp0_valid);
      end
    end
    @(posedge clk); #1; rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
        errors++; $display("FAIL midrst_stale k=%0d got=%b%b exp=00", k, rsp1_valid, rsp0_valid);
      end
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      req1_valid = 1'b0;
      req0_valid = (i < 2);
      req0_addr  = (i == 0) ? 5'd31 : 5'd0;
      @(negedge clk);
      if (i >= 2) begin
        checks++;
        if (rsp0_valid !== (i < 4)) begin
          errors++; $display("FAIL wrap_valid i=%0d got=%b exp=%b", i, rsp0_valid, (i < 4));
        end
        if (i < 4) begin
          checks++;
          if (rsp_data !== ((i == 2) ? 8'h2F : 8'h10)) begin
            errors++; $display("FAIL wrap_data i=%0d got=%h exp=%h",
                               i, rsp_data, ((i == 2) ? 8'h2F : 8'h10));
          end
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      rst        = ($urandom_range(0, 49) == 0);
      req0_valid = $urandom_range(0, 3) != 0;
      req1_valid = $urandom_range(0, 3) != 0;
      req0_addr  = 5'($urandom);
      req1_addr  = 5'($urandom);
    end
    @(posedge clk); #1;
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    for (int i = 0; i < 4; i++) @(posedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL random_drain pending=%0d exp=0", sb.size());
    end
  endtask

`ifdef ROM_ARB_STATS_EN
  task automatic test_stats();
    @(posedge clk); #1; rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1; rst = 1'b0; req0_valid = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      req0_addr = 5'($urandom);
      @(posedge clk); #1;
    end
    req0_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (grant_cnt0 !== 16'hFFFF || m_cnt0 != 65535) begin
      errors++; $display("FAIL stats_cnt0 got=%h exp=ffff (model %0d)", grant_cnt0, m_cnt0);
    end
    checks++;
    if (grant_cnt1 !== 16'h0000) begin
      errors++; $display("FAIL stats_cnt1 got=%h exp=0000", grant_cnt1);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; req0_addr = '0; req1_addr = '0;
    test_reset();
    test_single();
    test_contention();
    test_streaming();
    test_reset_midflight();
    test_wrap();
    test_random();
`ifdef ROM_ARB_STATS_EN
    test_stats();
`endif
    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rom_read_arbiter.md
ROM_READ_ARBITER -- requirements
Module: rom_read_arbiter

Interface
REQ-001 SHALL take parameter ADDR_W, default 5, ROM address width.
REQ-002 SHALL take parameter DATA_W, default 8, ROM data width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports req0_valid / req1_valid  input  1  read request from requester 0 / 1.
REQ-006 SHALL have ports req0_addr / req1_addr  input  ADDR_W  requested ROM address.
REQ-007 SHALL have ports req0_ready / req1_ready  output  1  request accepted this cycle.
REQ-008 SHALL have ports rsp0_valid / rsp1_valid  output  1  read data valid for requester 0 / 1.
REQ-009 SHALL have port rsp_data  output  DATA_W  read data, shared, qualified by rsp0_valid/rsp1_valid.
REQ-010 SHALL have port rom_addr  output  ADDR_W  address to the single-port ROM (clka domain = clk).
REQ-011 SHALL have port rom_data  input  DATA_W  ROM douta; valid one cycle after the ROM samples rom_addr.

Function
REQ-012 SHALL accept a request when reqN_valid && reqN_ready in cycle N; no more than one acceptance per cycle.
REQ-013 SHALL drive reqN_ready combinationally from the valids: only one valid -> that requester ready; both valid -> the round-robin winner is ready; none valid -> both 0.
REQ-014 SHALL keep a 1-bit round-robin pointer (priority holder), reset value = requester 0, toggled to the non-granted requester only on acceptance.
REQ-015 SHALL register the accepted address into rom_addr at the end of cycle N; rom_addr SHALL hold its value when no request is accepted.
REQ-016 SHALL assert rspK_valid for exactly one cycle in cycle N+2 for the requester K accepted in cycle N; rsp_data SHALL equal rom_data in that cycle.
REQ-017 SHALL sustain throughput of one accepted request per cycle, with back-to-back responses in order of acceptance.
REQ-018 SHALL track in-flight requests in a 2-stage {valid, id} shift pipeline; a response SHALL never be stalled (requesters always accept responses).
REQ-019 SHALL never assert rsp0_valid and rsp1_valid in the same cycle.
REQ-020 SHALL allow a requester to hold valid with a changing address; only the address present in the acceptance cycle is used.

Reset
REQ-021 SHALL, while rst is high: req0_ready = req1_ready = 0, rsp0_valid = rsp1_valid = 0, rom_addr = 0, pointer = 0, and the in-flight pipeline cleared.
REQ-022 SHALL discard all in-flight requests when rst is asserted mid-operation; no response for them SHALL appear after rst is released.
REQ-023 SHALL accept requests from the first cycle after rst is deasserted.

Configuration
REQ-024 SHALL, with ROM_ARB_STATS_EN defined, provide outputs grant_cnt0 and grant_cnt1 (16 bits each): acceptance counters per requester, saturating at 16'hFFFF, cleared by rst.
REQ-025 SHALL, without ROM_ARB_STATS_EN, omit these ports and counters; all other behaviour is identical.

Structure
REQ-026 SHALL place ADDR_W/DATA_W defaults, the constant RSP_LATENCY = 2, and the requester-id type (1 bit) in shared package rom_arb_pkg.
REQ-027 SHALL implement the two-way round-robin selection as sub-module rom_arb_rr (inputs: valids and pointer; outputs: one-hot grant).

Verification
Bench ROM model: 1-cycle registered read, data = addr + 8'h10.

REQ-028 SHALL cover a single request: req0 addr 5'd3 in cycle 10 -> req0_ready=1 in cycle 10; rsp0_valid=1 with rsp_data=8'h13 in cycle 12 only.
REQ-029 SHALL cover a contention case: both valid continuously from reset, addrs 0 and 31 -> grants alternate 0,1,0,1; responses 8'h10 and 8'h2F alternate with 2-cycle latency.
REQ-030 SHALL cover streaming: req1 valid for 8 cycles, addrs 0..7 -> 8 consecutive rsp1_valid cycles, data 8'h10..8'h17.
REQ-031 SHALL cover reset mid-flight: rst asserted in cycle N+1 after an acceptance in cycle N -> no rspX_valid in cycles N+2 and N+3; ready=0 while rst is high.
REQ-032 SHALL cover stats (with ROM_ARB_STATS_EN): 70000 req0 acceptances -> grant_cnt0 = 16'hFFFF and grant_cnt1 = 0.
REQ-033 SHALL cover address wrap: requests to addr 31 then addr 0 -> data 8'h2F then 8'h10, with no stale data.
